// File: rtl/servile_rr_arbiter.sv
// servile_rr_arbiter
// Shares the single servile memory port between the SERV instruction bus (ibus,
// read-only) and data bus (dbus). The grant is registered: a request seen in
// one cycle drives the memory strobe in the next. When both masters request at
// once, the master that was not granted last wins. A per-access watchdog
// completes a hung access with a zero-data ack and a one-cycle o_timeout pulse.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_wb_ibus_*           ibus request side: adr, stb
//   o_wb_ibus_*           ibus response side: rdt, ack
//   i_wb_dbus_*           dbus request side: adr, dat, sel, we, stb
//   o_wb_dbus_*           dbus response side: rdt, ack
//   o_wb_mem_*            memory request side: adr, dat, sel, we, stb
//   i_wb_mem_*            memory response side: rdt, ack
//   o_timeout             pulses for one cycle on a watchdog-forced completion
//   o_busy                high while either master holds the grant
module servile_rr_arbiter #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_ibus_adr,
  input  logic        i_wb_ibus_stb,
  output logic [31:0] o_wb_ibus_rdt,
  output logic        o_wb_ibus_ack,
  input  logic [31:0] i_wb_dbus_adr,
  input  logic [31:0] i_wb_dbus_dat,
  input  logic [3:0]  i_wb_dbus_sel,
  input  logic        i_wb_dbus_we,
  input  logic        i_wb_dbus_stb,
  output logic [31:0] o_wb_dbus_rdt,
  output logic        o_wb_dbus_ack,
  output logic [31:0] o_wb_mem_adr,
  output logic [31:0] o_wb_mem_dat,
  output logic [3:0]  o_wb_mem_sel,
  output logic        o_wb_mem_we,
  output logic        o_wb_mem_stb,
  input  logic [31:0] i_wb_mem_rdt,
  input  logic        i_wb_mem_ack,
  output logic        o_timeout,
  output logic        o_busy
);

  // With TIMEOUT=0 the derived width collapses to zero; keep a 1-bit counter.
  localparam int unsigned CW = (TW < 1) ? 1 : TW;
  localparam logic [CW-1:0] CntLast = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CntMax  = '1;
  localparam logic          WdogEn  = (TIMEOUT > 0);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

  state_e        state_q, state_d;
  logic          last_dbus_q, last_dbus_d;  // 1: dbus held the most recent grant
  logic [CW-1:0] cnt_q, cnt_d;

  logic grant_i, grant_d;
  logic req_granted;
  logic wdog_fire;

  assign grant_i = (state_q == StGrantI);
  assign grant_d = (state_q == StGrantD);

  always_comb begin
    req_granted = 1'b0;
    if (grant_i) req_granted = i_wb_ibus_stb;
    if (grant_d) req_granted = i_wb_dbus_stb;
  end

  // A real ack in the final watchdog cycle wins over the forced completion.
  assign wdog_fire = WdogEn & req_granted & ~i_wb_mem_ack & (cnt_q == CntLast);

  // Memory port mux; everything reads as zero while idle.
  always_comb begin
    o_wb_mem_adr = '0;
    o_wb_mem_dat = '0;
    o_wb_mem_sel = '0;
    o_wb_mem_we  = 1'b0;
    o_wb_mem_stb = 1'b0;
    unique case (state_q)
      StGrantI: begin
        o_wb_mem_adr = i_wb_ibus_adr;
        o_wb_mem_sel = 4'hF;
        o_wb_mem_stb = i_wb_ibus_stb & ~wdog_fire;
      end
      StGrantD: begin
        o_wb_mem_adr = i_wb_dbus_adr;
        o_wb_mem_dat = i_wb_dbus_dat;
        o_wb_mem_sel = i_wb_dbus_sel;
        o_wb_mem_we  = i_wb_dbus_we;
        o_wb_mem_stb = i_wb_dbus_stb & ~wdog_fire;
      end
      default: ;
    endcase
  end

  // Response routing; a forced completion returns zero data.
  assign o_wb_ibus_ack = grant_i & (i_wb_mem_ack | wdog_fire);
  assign o_wb_dbus_ack = grant_d & (i_wb_mem_ack | wdog_fire);
  assign o_wb_ibus_rdt = (grant_i & ~wdog_fire) ? i_wb_mem_rdt : 32'h0;
  assign o_wb_dbus_rdt = (grant_d & ~wdog_fire) ? i_wb_mem_rdt : 32'h0;
  assign o_timeout     = wdog_fire;
  assign o_busy        = grant_i | grant_d;

  always_comb begin
    state_d     = state_q;
    last_dbus_d = last_dbus_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_wb_ibus_stb && (!i_wb_dbus_stb || last_dbus_q)) begin
          state_d     = StGrantI;
          last_dbus_d = 1'b0;
          cnt_d       = '0;
        end else if (i_wb_dbus_stb) begin
          state_d     = StGrantD;
          last_dbus_d = 1'b1;
          cnt_d       = '0;
        end
      end
      StGrantI, StGrantD: begin
        if (!i_wb_mem_ack && (cnt_q != CntMax)) cnt_d = cnt_q + 1'b1;
        // Completion, abandoned request or watchdog all return to arbitration.
        if (i_wb_mem_ack || !req_granted || wdog_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      last_dbus_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_dbus_q <= last_dbus_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
